// File: rtl/mcdf_pkg.sv
// Shared types and constants for the MCDF arbiter slice.
//   NUM_CH      : number of channel slaves feeding the arbiter
//   DW_DEF      : default data width of slave and formatter buses
//   chan_id_t   : channel index (0..NUM_CH-1)
//   prio_t      : channel priority, 0 is highest
//   arb_state_e : arbiter FSM states
//   rr_next     : (base + step) mod NUM_CH for the round-robin scan
package mcdf_pkg;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned DW_DEF = 32;

  typedef logic [1:0] chan_id_t;
  typedef logic [1:0] prio_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // base is at most 2 and step at most 3, so two conditional subtracts cover the mod
  function automatic chan_id_t rr_next(chan_id_t base, logic [1:0] step);
    logic [2:0] sum;
    sum = 3'({1'b0, base}) + 3'({1'b0, step});
    if (sum >= 3'd3) sum = sum - 3'd3;
    if (sum >= 3'd3) sum = sum - 3'd3;
    return chan_id_t'(sum[1:0]);
  endfunction

endpackage

// File: rtl/mcdf_arb_if.sv
// Slave-to-arbiter and arbiter-to-formatter signal bundle.
//   slave  modport : arbiter side (responder)
//   master modport : channel slaves, register block and formatter side
// Signal names carry the arbiter's point of view (_i into, _o out of the arbiter).
interface mcdf_arb_if #(
  parameter int unsigned DW = mcdf_pkg::DW_DEF
) ();

  mcdf_pkg::prio_t    slv0_prio_i, slv1_prio_i, slv2_prio_i;
  logic               slv0_req_i,  slv1_req_i,  slv2_req_i;
  logic               slv0_val_i,  slv1_val_i,  slv2_val_i;
  logic [DW-1:0]      slv0_data_i, slv1_data_i, slv2_data_i;
  logic               a2s0_ack_o,  a2s1_ack_o,  a2s2_ack_o;
  logic               f2a_rdy_i;
  logic               a2f_val_o;
  mcdf_pkg::chan_id_t a2f_id_o;
  logic [DW-1:0]      a2f_data_o;

  modport slave (
    input  slv0_prio_i, slv1_prio_i, slv2_prio_i,
    input  slv0_req_i,  slv1_req_i,  slv2_req_i,
    input  slv0_val_i,  slv1_val_i,  slv2_val_i,
    input  slv0_data_i, slv1_data_i, slv2_data_i,
    input  f2a_rdy_i,
    output a2s0_ack_o,  a2s1_ack_o,  a2s2_ack_o,
    output a2f_val_o,   a2f_id_o,    a2f_data_o
  );

  modport master (
    output slv0_prio_i, slv1_prio_i, slv2_prio_i,
    output slv0_req_i,  slv1_req_i,  slv2_req_i,
    output slv0_val_i,  slv1_val_i,  slv2_val_i,
    output slv0_data_i, slv1_data_i, slv2_data_i,
    output f2a_rdy_i,
    input  a2s0_ack_o,  a2s1_ack_o,  a2s2_ack_o,
    input  a2f_val_o,   a2f_id_o,    a2f_data_o
  );

endinterface

// File: rtl/mcdf_rr_prio_sel.sv
// Combinational winner selection: lowest priority value wins, ties broken
// round-robin starting after last_id.
//   req_i       : per-channel request
//   prio_i      : per-channel priority (0 highest)
//   last_id_i   : channel granted most recently
//   any_req_c_o : at least one channel requests
//   winner_c_o  : selected channel (meaningful only when any_req_c_o)
module mcdf_rr_prio_sel
  import mcdf_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  prio_t [NUM_CH-1:0] prio_i,
  input  chan_id_t           last_id_i,
  output logic               any_req_c_o,
  output chan_id_t           winner_c_o
);

  prio_t      min_prio;
  logic [3:0] cand;      // one spare bit so any 2-bit index stays in range
  chan_id_t   idx;
  logic       found;

  always_comb begin
    min_prio = 2'd3;
    cand     = '0;
    idx      = '0;
    found    = 1'b0;
    winner_c_o = last_id_i;
    // best priority among requesters
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (req_i[i] && (prio_i[i] < min_prio)) min_prio = prio_i[i];
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cand[i] = req_i[i] && (prio_i[i] == min_prio);
    end
    // scan last+1, last+2, last+3 (mod 3)
    for (int k = 1; k <= 3; k++) begin
      idx = rr_next(last_id_i, 2'(k));
      if (!found && cand[idx]) begin
        winner_c_o = idx;
        found      = 1'b1;
      end
    end
  end

  assign any_req_c_o = |req_i;

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: grants one channel slave at a time for up to BURST_LEN words
// and forwards each accepted word, tagged with its channel, one cycle later.
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous reset, active-high
//   bus    : slave modport of mcdf_arb_if (slave req/val/data/prio, acks,
//            formatter rdy and forwarded val/id/data)
module mcdf_arbiter
  import mcdf_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic     clk_i,
  input  logic     rstn_i,
  mcdf_arb_if.slave bus
);

  localparam int unsigned CW = $clog2(BURST_LEN + 1);

  arb_state_e          state_q;
  chan_id_t            gnt_id_q, last_id_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]   ack_q;
  logic                fwd_val_q;
  chan_id_t            fwd_id_q;
  logic [DW-1:0]       fwd_data_q;

  logic [NUM_CH-1:0]   req;
  prio_t [NUM_CH-1:0]  prio;
  logic                any_req;
  chan_id_t            winner;
  logic                cur_req, cur_val, last_word;
  logic [DW-1:0]       cur_data;

  assign req  = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
  assign prio = {bus.slv2_prio_i, bus.slv1_prio_i, bus.slv0_prio_i};

  mcdf_rr_prio_sel u_sel (
    .req_i       (req),
    .prio_i      (prio),
    .last_id_i   (last_id_q),
    .any_req_c_o (any_req),
    .winner_c_o  (winner)
  );

  // mux the granted channel's handshake and data
  always_comb begin
    cur_req  = bus.slv0_req_i;
    cur_val  = bus.slv0_val_i;
    cur_data = bus.slv0_data_i;
    case (gnt_id_q)
      2'd1: begin
        cur_req  = bus.slv1_req_i;
        cur_val  = bus.slv1_val_i;
        cur_data = bus.slv1_data_i;
      end
      2'd2: begin
        cur_req  = bus.slv2_req_i;
        cur_val  = bus.slv2_val_i;
        cur_data = bus.slv2_data_i;
      end
      default: ;
    endcase
  end

  assign cnt_d     = cnt_q + CW'(1);
  assign last_word = (cnt_q == CW'(BURST_LEN - 1));

  // FSM, burst counter and forwarding registers
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      state_q    <= IDLE;
      gnt_id_q   <= '0;
      last_id_q  <= chan_id_t'(2);
      cnt_q      <= '0;
      ack_q      <= '0;
      fwd_val_q  <= 1'b0;
      fwd_id_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_val_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.f2a_rdy_i && any_req) begin
            gnt_id_q  <= winner;
            last_id_q <= winner;
            cnt_q     <= '0;
            ack_q     <= NUM_CH'(1) << winner;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          if (cur_val) begin
            fwd_val_q  <= 1'b1;
            fwd_id_q   <= gnt_id_q;
            fwd_data_q <= cur_data;
            cnt_q      <= cnt_d;
            if (last_word) begin
              ack_q   <= '0;
              state_q <= IDLE;
            end
          end else if (!cur_req) begin
            // slave drained before the burst limit
            ack_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a2s0_ack_o = ack_q[0];
  assign bus.a2s1_ack_o = ack_q[1];
  assign bus.a2s2_ack_o = ack_q[2];
  assign bus.a2f_val_o  = fwd_val_q;
  assign bus.a2f_id_o   = fwd_id_q;
  assign bus.a2f_data_o = fwd_data_q;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Self-checking bench for mcdf_arbiter: slaves are FIFO queues, expected
// behaviour comes from a cycle model of the grant/forward rules.
module tb_mcdf_arbiter;

  localparam int BL = 4;

  logic clk, rstn;
  mcdf_arb_if #(.DW(32)) bus ();

  mcdf_arbiter #(.DW(32), .BURST_LEN(BL)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  // slave contract: val = ack & req, combinational
  assign bus.slv0_val_i = bus.a2s0_ack_o & bus.slv0_req_i;
  assign bus.slv1_val_i = bus.a2s1_ack_o & bus.slv1_req_i;
  assign bus.slv2_val_i = bus.a2s2_ack_o & bus.slv2_req_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] fifo [3][$];
  int          prio [3];
  logic        rdy;

  int          checks, errors;
  int          m_gnt, m_cnt, m_last, m_fid;
  logic        m_fval;
  logic [31:0] m_fdata;

  int          glog [$];
  int          ack_cyc [3];
  int          fwd_cnt;
  logic [2:0]  prev_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.slv0_req_i  = fifo[0].size() != 0;
    bus.slv1_req_i  = fifo[1].size() != 0;
    bus.slv2_req_i  = fifo[2].size() != 0;
    bus.slv0_data_i = (fifo[0].size() != 0) ? fifo[0][0] : 32'd0;
    bus.slv1_data_i = (fifo[1].size() != 0) ? fifo[1][0] : 32'd0;
    bus.slv2_data_i = (fifo[2].size() != 0) ? fifo[2][0] : 32'd0;
    bus.slv0_prio_i = 2'(prio[0]);
    bus.slv1_prio_i = 2'(prio[1]);
    bus.slv2_prio_i = 2'(prio[2]);
    bus.f2a_rdy_i   = rdy;
  endtask

  // lowest prio among non-empty slaves, first in rotation after m_last
  function automatic int pick();
    int best = 4;
    for (int i = 0; i < 3; i++)
      if (fifo[i].size() != 0 && prio[i] < best) best = prio[i];
    for (int k = 1; k <= 3; k++) begin
      int c = (m_last + k) % 3;
      if (fifo[c].size() != 0 && prio[c] == best) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_cnt = 0; m_last = 2; m_fval = 1'b0; m_fid = 0; m_fdata = 32'd0;
    prev_ack = 3'b000;
  endtask

  // one clock: drive, check outputs, advance model, clock, pop accepted words
  task automatic cycle();
    logic [2:0] ackv, popv;
    int w;
    drive();
    #1;
    ackv = {bus.a2s2_ack_o, bus.a2s1_ack_o, bus.a2s0_ack_o};
    chk("ack", 32'(ackv), (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
    chk("a2f_val", 32'(bus.a2f_val_o), 32'(m_fval));
    if (m_fval) begin
      chk("a2f_id", 32'(bus.a2f_id_o), 32'(m_fid));
      chk("a2f_data", bus.a2f_data_o, m_fdata);
    end
    if (ackv != 3'b000 && prev_ack == 3'b000) glog.push_back(ackv[2] ? 2 : (ackv[1] ? 1 : 0));
    prev_ack = ackv;
    for (int i = 0; i < 3; i++) ack_cyc[i] += int'(ackv[i]);
    fwd_cnt += int'(bus.a2f_val_o);
    if (m_gnt < 0) begin
      m_fval = 1'b0;
      if (rdy) begin
        w = pick();
        if (w >= 0) begin m_gnt = w; m_last = w; m_cnt = 0; end
      end
    end else if (fifo[m_gnt].size() != 0) begin
      m_fval = 1'b1; m_fid = m_gnt; m_fdata = fifo[m_gnt][0];
      m_cnt++;
      if (m_cnt == BL) m_gnt = -1;
    end else begin
      m_fval = 1'b0; m_gnt = -1;
    end
    popv = {bus.slv2_val_i, bus.slv1_val_i, bus.slv0_val_i};
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (popv[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_stats();
    glog.delete();
    fwd_cnt = 0;
    for (int i = 0; i < 3; i++) ack_cyc[i] = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    #1;
    chk("rst_ack", 32'({bus.a2s2_ack_o, bus.a2s1_ack_o, bus.a2s0_ack_o}), 32'd0);
    chk("rst_a2f_val", 32'(bus.a2f_val_o), 32'd0);
    chk("rst_a2f_id", 32'(bus.a2f_id_o), 32'd0);
    chk("rst_a2f_data", bus.a2f_data_o, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
  endtask

  task automatic fill(input int ch, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) fifo[ch].push_back(base + 32'(i));
  endtask

  initial begin
    int exp2 [4];
    int exp3 [5];
    checks = 0; errors = 0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) prio[i] = 0;
    model_reset();
    clear_stats();
    rstn = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // two full bursts from channel 0
    rdy = 1'b1;
    fill(0, 8, 32'h00C0_0000);
    run(13);
    chk("t1_grants", 32'(glog.size()), 32'd2);
    chk("t1_ack_cycles", 32'(ack_cyc[0]), 32'd8);
    chk("t1_fwd_words", 32'(fwd_cnt), 32'd8);

    // equal priorities rotate 0,1,2,0
    do_reset();
    clear_stats();
    for (int i = 0; i < 3; i++) prio[i] = 1;
    fill(0, 8, 32'hA000_0000);
    fill(1, 4, 32'hA100_0000);
    fill(2, 4, 32'hA200_0000);
    run(24);
    exp2 = '{0, 1, 2, 0};
    chk("t2_grants", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_order", 32'(glog[i]), 32'(exp2[i]));

    // channel 2 dominates until drained, then 0/1 alternate
    clear_stats();
    prio[0] = 3; prio[1] = 3; prio[2] = 0;
    fill(2, 6, 32'hB200_0000);
    fill(0, 8, 32'hB000_0000);
    fill(1, 4, 32'hB100_0000);
    run(30);
    exp3 = '{2, 2, 0, 1, 0};
    chk("t3_grants", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("t3_order", 32'(glog[i]), 32'(exp3[i]));

    // short burst: 2 words, ack 3 cycles
    clear_stats();
    fill(1, 2, 32'hC100_0000);
    run(8);
    chk("t4_ack_cycles", 32'(ack_cyc[1]), 32'd3);
    chk("t4_fwd_words", 32'(fwd_cnt), 32'd2);
    chk("t4_grants", 32'(glog.size()), 32'd1);

    // formatter not ready holds off all grants
    clear_stats();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) prio[i] = 0;
    fill(0, 3, 32'hD000_0000);
    fill(2, 3, 32'hD200_0000);
    run(10);
    chk("t5_no_grant", 32'(glog.size()), 32'd0);
    chk("t5_no_fwd", 32'(fwd_cnt), 32'd0);
    rdy = 1'b1;
    run(2);
    chk("t5_grant_after_rdy", 32'(glog.size()), 32'd1);
    run(12);

    // reset in the middle of a burst
    fill(0, 8, 32'hE000_0000);
    run(3);
    do_reset();
    clear_stats();
    fill(1, 4, 32'hE100_0000);
    fill(2, 4, 32'hE200_0000);
    run(20);
    chk("t6_first_tie", 32'(glog[0]), 32'd0);
    run(30);

    // random traffic, priorities and ready
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) fifo[$urandom_range(0, 2)].push_back($urandom);
      if ($urandom_range(0, 7) == 0) prio[$urandom_range(0, 2)] = int'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 4) != 0);
      cycle();
    end
    rdy = 1'b1;
    run(80);
    chk("drain_empty", 32'(fifo[0].size() + fifo[1].size() + fifo[2].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcdf_arbiter.md
Name: mcdf_arbiter

Overview:
- Responder side of the slave-to-arbiter req/ack interface.
- Collects bursts from three channel slaves and forwards each word to the formatter, tagged with its channel id.
- Selects the next source by per-channel priority from the register block, with round-robin among equal priorities.
- Grants one slave at a time for a burst of at most BURST_LEN words.

Parameters:
- DW, 32, data width of slave and formatter data buses.
- BURST_LEN, 4, maximum words accepted per grant (range 1..255).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-high.
- slv0_prio_i / slv1_prio_i / slv2_prio_i  in  2 each  channel priority from registers; 0 is highest.
- slv0_req_i / slv1_req_i / slv2_req_i  in  1 each  slave has data (FIFO not empty).
- slv0_val_i / slv1_val_i / slv2_val_i  in  1 each  word valid this cycle.
- slv0_data_i / slv1_data_i / slv2_data_i  in  DW each  word payload.
- a2s0_ack_o / a2s1_ack_o / a2s2_ack_o  out  1 each  grant/ack to slave.
- f2a_rdy_i  in  1  formatter can absorb a full burst of BURST_LEN words.
- a2f_val_o  out  1  forwarded word valid.
- a2f_id_o  out  2  source channel of forwarded word (0..2).
- a2f_data_o  out  DW  forwarded word.

Behaviour:
- Slave contract (decided):
  - slvx_val_i = a2sx_ack_o & slvx_req_i, combinational in the slave.
  - slvx_data_i is the show-ahead FIFO head.
  - The slave pops on each clock edge where val is high.
- Reset:
  - All acks, a2f_val_o, a2f_id_o and a2f_data_o = 0.
  - state = IDLE, word counter = 0, last_id = 2, so channel 0 wins the first round-robin tie.
  - Reset mid-burst aborts immediately; no forwarded word is emitted after reset.
- FSM states: IDLE, GRANT.
- IDLE:
  - When f2a_rdy_i = 1 and any req = 1, register the winner id into gnt_id, clear the counter and go to GRANT next cycle.
  - Otherwise stay in IDLE.
  - No ack is asserted in IDLE.
- Winner selection:
  - Among requesting channels, take those with the numerically lowest prio.
  - Break ties by scanning last_id+1, last_id+2, last_id+3 (mod 3); the first match wins.
  - last_id is updated to the winner when GRANT is entered.
- GRANT:
  - a2s[gnt_id]_ack_o = 1, decoded from registered state and gnt_id; all other acks are 0.
  - Each cycle with slv[gnt_id]_val_i = 1, the counter increments.
  - The next cycle: a2f_val_o = 1, a2f_id_o = gnt_id, a2f_data_o = the word. This is fixed 1-cycle latency; forwarding registers are loaded only when val = 1.
- GRANT exit, back to IDLE on the next edge, on either condition:
  - val = 1 and counter == BURST_LEN-1 (burst complete), or
  - slv[gnt_id]_req_i = 0 (slave drained early; no word that cycle).
- Minimum one IDLE cycle between grants; back-to-back grants to the same channel are allowed.
- Priority inputs are sampled only in IDLE; changes during GRANT are ignored for the current burst.
- f2a_rdy_i is checked only at grant time; a deassertion during GRANT does not stall.
- val from a non-granted slave, or any val in IDLE, is ignored (protocol error, no forwarding).
- a2f_val_o is low in every cycle not directly following an accepted word.
- Counter width: $clog2(BURST_LEN+1); it never wraps because exit occurs at BURST_LEN-1.
- Throughput: BURST_LEN words per BURST_LEN+1 cycles when slaves stay non-empty.

Decomposition:
- Package mcdf_pkg holds:
  - arb_state_e (IDLE, GRANT);
  - typedef chan_id_t (logic [1:0]);
  - constant NUM_CH = 3;
  - DW default.
- One sub-module, mcdf_rr_prio_sel: combinational winner selection.
  - Inputs: req[2:0], prio[2:0][1:0], last_id.
  - Outputs: any_req, winner id.
- The FSM, counter and forwarding registers stay in the top module.

Test Plan:
- Reset, then slv0 req with 8 words 0x00C0_0000..7, prio 0, f2a_rdy_i = 1 -> two grants:
  - a2s0_ack_o high 4 cycles each, one IDLE cycle between grants;
  - a2f_data_o = 0x00C0_0000..7 in order, a2f_id_o = 0, each word 1 cycle after its val.
- All three req, all prio 1 -> grant order 0, 1, 2, 0; the id sequence of forwarded bursts matches.
- slv2 prio 0, slv0 and slv1 prio 3, all requesting -> channel 2 wins every grant until its req drops, then 0 and 1 alternate.
- slv1 has 2 words, BURST_LEN = 4 -> ack high 3 cycles (2 val + 1 cycle req low); exactly 2 forwarded words; return to IDLE.
- f2a_rdy_i = 0 with reqs pending -> no ack and no a2f_val_o for 10 cycles; rdy = 1 -> grant on the next cycle.
- rstn_i pulsed after the 2nd word of a burst -> acks and a2f_val_o low immediately; after release, channel 0 wins the first tie.
